// File: rtl/otn_frame_rx.sv
// otn_frame_rx: serial FAS hunt/deframer with BIP-8 check and ARQ verdicts.
// Optional macro OTN_RX_ARQ_EN compiles in the BIP-8 checker and ack/nack.
module otn_frame_rx #(
  parameter int          FRAME_BITS  = 1024,
  parameter logic [15:0] FAS_PATTERN = 16'hF628,
  parameter int          LOS_COUNT   = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_otn_rx_data,
  input  logic i_otn_rx_valid,
  input  logic i_arq_en,
  output logic o_frame_data,
  output logic o_frame_data_valid,
  output logic o_frame_data_fas,
  output logic o_frame_end,
  output logic o_in_sync,
  output logic o_otn_tx_ack,
  output logic o_retrans_req
);

  localparam int IW = $clog2(FRAME_BITS);
  localparam logic [IW-1:0] IDX_FAS_END = IW'(15);
  localparam logic [IW-1:0] IDX_PL0     = IW'(16);
  localparam logic [IW-1:0] IDX_PL_END  = IW'(FRAME_BITS - 9);
  localparam logic [IW-1:0] IDX_LAST    = IW'(FRAME_BITS - 1);
  localparam logic [7:0]    LOS         = 8'(LOS_COUNT);

  typedef enum logic [1:0] {HUNT, PRESYNC, SYNC} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   sr_q, sr_d;
  logic [7:0]    miss_q;
  logic          fwd_q, fwd_d;
  logic          data_q, dv_q, fas_q, end_q, sync_q;
  logic          match, at_fas_end, at_pl0, at_pl_end, in_pl;

  always_comb begin
    sr_d       = {sr_q[14:0], i_otn_rx_data};
    match      = (sr_d == FAS_PATTERN);
    at_fas_end = (idx_q == IDX_FAS_END);
    at_pl0     = (idx_q == IDX_PL0);
    at_pl_end  = (idx_q == IDX_PL_END);
    in_pl      = (idx_q >= IDX_PL0) && (idx_q <= IDX_PL_END);
    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    // forwarding decision for a frame is taken on its first payload bit
    fwd_d      = at_pl0 ? (state_q == SYNC) : fwd_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HUNT;
      idx_q   <= '0;
      sr_q    <= '0;
      miss_q  <= '0;
      fwd_q   <= 1'b0;
      data_q  <= 1'b0;
      dv_q    <= 1'b0;
      fas_q   <= 1'b0;
      end_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      dv_q  <= 1'b0;
      fas_q <= 1'b0;
      end_q <= 1'b0;
      if (i_otn_rx_valid) begin
        sr_q   <= sr_d;
        idx_q  <= idx_d;
        fwd_q  <= fwd_d;
        data_q <= i_otn_rx_data & fwd_d & in_pl;
        dv_q   <= fwd_d & in_pl;
        fas_q  <= fwd_d & at_pl0;
        end_q  <= fwd_d & at_pl_end;
        unique case (state_q)
          HUNT: begin
            if (match) begin
              state_q <= PRESYNC;
              idx_q   <= IDX_PL0;
            end
          end
          PRESYNC: begin
            if (at_fas_end) begin
              if (match) begin
                state_q <= SYNC;
                sync_q  <= 1'b1;
              end else begin
                state_q <= HUNT;
              end
            end
          end
          SYNC: begin
            if (at_fas_end) begin
              if (match) begin
                miss_q <= '0;
              end else if (miss_q + 8'd1 == LOS) begin
                miss_q  <= '0;
                state_q <= HUNT;
                sync_q  <= 1'b0;
              end else begin
                miss_q <= miss_q + 8'd1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign o_frame_data       = data_q;
  assign o_frame_data_valid = dv_q;
  assign o_frame_data_fas   = fas_q;
  assign o_frame_end        = end_q;
  assign o_in_sync          = sync_q;

  logic unused_bits;

`ifdef OTN_RX_ARQ_EN
  logic [7:0] bip_q;
  logic       err_q, ack_q, retr_q;
  logic       in_trl, bit_err, err_all;
  logic [2:0] j;

  always_comb begin
    j       = idx_q[2:0];
    in_trl  = (idx_q > IDX_PL_END);
    bit_err = i_otn_rx_data ^ bip_q[j];
    err_all = err_q | bit_err;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bip_q  <= '0;
      err_q  <= 1'b0;
      ack_q  <= 1'b0;
      retr_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      retr_q <= 1'b0;
      if (i_otn_rx_valid) begin
        if (at_pl0) begin
          bip_q <= {7'd0, i_otn_rx_data};
          err_q <= 1'b0;
        end else if (in_pl) begin
          bip_q[j] <= bip_q[j] ^ i_otn_rx_data;
        end else if (in_trl) begin
          err_q <= err_all;
        end
        if (idx_q == IDX_LAST && fwd_q && i_arq_en) begin
          ack_q  <= ~err_all;
          retr_q <= err_all;
        end
      end
    end
  end

  assign o_otn_tx_ack  = ack_q;
  assign o_retrans_req = retr_q;
  assign unused_bits   = sr_q[15];
`else
  assign o_otn_tx_ack  = 1'b0;
  assign o_retrans_req = 1'b0;
  assign unused_bits   = sr_q[15] ^ i_arq_en;
`endif

endmodule

// File: tb/tb_otn_frame_rx.sv
// Scoreboard bench for otn_frame_rx with FRAME_BITS=64 (40-bit payload).
// Verdict expectations follow OTN_RX_ARQ_EN when it is defined.
module tb_otn_frame_rx;

  localparam int          FB  = 64;
  localparam logic [15:0] FAS = 16'hF628;
  localparam logic [15:0] BAD = 16'h0000;
`ifdef OTN_RX_ARQ_EN
  localparam bit ARQ = 1'b1;
`else
  localparam bit ARQ = 1'b0;
`endif

  localparam logic [39:0] P0 = 40'h20_10_04_02_01;
  localparam logic [39:0] PA = 40'hC3_5A_96_0F_E1;
  localparam logic [39:0] PB = 40'h12_34_56_78_9A;
  localparam logic [39:0] PC = 40'hFE_DC_BA_98_76;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_d = 1'b0;
  logic rx_v = 1'b0;
  logic arq = 1'b1;
  logic o_d, o_dv, o_fas, o_end, o_sync, o_ack, o_retr;

  otn_frame_rx #(.FRAME_BITS(FB)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_otn_rx_data      (rx_d),
    .i_otn_rx_valid     (rx_v),
    .i_arq_en           (arq),
    .o_frame_data       (o_d),
    .o_frame_data_valid (o_dv),
    .o_frame_data_fas   (o_fas),
    .o_frame_end        (o_end),
    .o_in_sync          (o_sync),
    .o_otn_tx_ack       (o_ack),
    .o_retrans_req      (o_retr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit gapmode = 1'b0;

  logic [2:0] exp_q[$];
  bit         vkind[$];
  int         vcyc[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [7:0] bip_of(input logic [39:0] pl);
    return pl[7:0] ^ pl[15:8] ^ pl[23:16] ^ pl[31:24] ^ pl[39:32];
  endfunction

  task automatic sendb(input logic b);
    int n;
    if (gapmode) begin
      n = ($urandom_range(0, 5) == 0) ? 10 : $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
    rx_d = b;
    rx_v = 1'b1;
    @(posedge clk);
    #1;
    rx_v = 1'b0;
  endtask

  // fwd: frame payload expected at the output; sync: o_in_sync after FAS
  task automatic send_frame(input logic [15:0] fas, input logic [39:0] pl,
                            input bit flip, input bit fwd, input bit sync,
                            input int upto);
    logic [39:0] tx;
    logic [7:0]  bip;
    tx  = pl ^ (flip ? 40'h8 : 40'h0);
    bip = bip_of(pl);
    if (fwd)
      for (int p = 0; p < 40; p++)
        exp_q.push_back({tx[p], p == 0, p == 39});
    for (int i = 0; i < upto; i++) begin
      if (i < 16)      sendb(fas[15-i]);
      else if (i < 56) sendb(tx[i-16]);
      else             sendb(bip[i-56]);
      if (i == 15) chk("in_sync_after_fas", 32'(o_sync), 32'(sync));
      if (i == FB - 1 && fwd && ARQ && arq) begin
        vkind.push_back(flip);
        vcyc.push_back(cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    bit k;
    int c;
    if (rst_n) begin
      if (o_dv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL payload_extra: got bit %0b want none", o_d);
        end else begin
          e = exp_q.pop_front();
          chk("payload", {29'd0, o_d, o_fas, o_end}, {29'd0, e});
        end
      end else if (o_fas || o_end) begin
        checks++;
        errors++;
        $display("FAIL marker_no_valid: got fas=%0b end=%0b want 0",
                 o_fas, o_end);
      end
      if (o_ack || o_retr) begin
        if (vkind.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL verdict_extra: got ack=%0b retr=%0b want none",
                   o_ack, o_retr);
        end else begin
          k = vkind.pop_front();
          c = vcyc.pop_front();
          chk("verdict", {30'd0, o_ack, o_retr},
              k ? 32'd1 : 32'd2);
          chk("verdict_cycle", 32'(cyc), 32'(c));
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_dv", 32'(o_dv), 0);
    chk("rst_d", 32'(o_d), 0);
    chk("rst_fas", 32'(o_fas), 0);
    chk("rst_end", 32'(o_end), 0);
    chk("rst_sync", 32'(o_sync), 0);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_retr", 32'(o_retr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // alignment: 5 stray bits, then PRESYNC frame, then forwarded frames
    sendb(1'b1); sendb(1'b0); sendb(1'b1); sendb(1'b0); sendb(1'b1);
    send_frame(FAS, P0, 0, 0, 0, FB);
    send_frame(FAS, PA, 0, 1, 1, FB);
    send_frame(FAS, PB, 0, 1, 1, FB);

    // BIP error with and without ARQ enable
    send_frame(FAS, PC, 1, 1, 1, FB);
    arq = 1'b0;
    send_frame(FAS, PC, 1, 1, 1, FB);
    arq = 1'b1;
    send_frame(FAS, PA, 0, 1, 1, FB);

    // flywheel: two misses tolerated, counter cleared by good FAS
    send_frame(BAD, PB, 0, 1, 1, FB);
    send_frame(BAD, PC, 0, 1, 1, FB);
    send_frame(FAS, PA, 0, 1, 1, FB);

    // loss on third miss, then resync after two good FAS
    send_frame(BAD, PB, 0, 1, 1, FB);
    send_frame(BAD, PC, 0, 1, 1, FB);
    send_frame(BAD, P0, 0, 0, 0, FB);
    send_frame(FAS, P0, 0, 0, 0, FB);
    send_frame(FAS, PB, 0, 1, 1, FB);

    // strobe gaps
    gapmode = 1'b1;
    send_frame(FAS, PA, 0, 1, 1, FB);
    send_frame(FAS, PB, 1, 1, 1, FB);
    send_frame(FAS, PC, 0, 1, 1, FB);
    gapmode = 1'b0;

    // reset mid-stream while payload is being forwarded
    send_frame(FAS, PA, 0, 1, 1, 30);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", 32'(o_dv), 0);
    chk("midrst_d", 32'(o_d), 0);
    chk("midrst_sync", 32'(o_sync), 0);
    chk("midrst_ack", 32'(o_ack | o_retr), 0);
    exp_q.delete();
    vkind.delete();
    vcyc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(FAS, PB, 0, 0, 0, FB);
    send_frame(FAS, PC, 0, 1, 1, FB);

    repeat (5) @(posedge clk);
    #1;
    chk("payload_drained", 32'(exp_q.size()), 0);
    chk("verdict_drained", 32'(vkind.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otn_frame_rx.md
# otn_frame_rx

Receive-side deframer for the serial OTN-style link: takes the serial bit stream arriving from the far-end sender and hunts for frame alignment on the 16-bit FAS. Once aligned, it forwards payload bits to the demapper and checks each frame's BIP-8 trailer. It returns ack/retransmit indications toward the sender's ARQ logic. It is the peer of the sender's transmit/receive block: it consumes what that block puts on the wire and produces its `ack`/`retrans` inputs.

## Interface
Parameters:
- `FRAME_BITS`, 1024 — total bits per frame: FAS + payload + BIP-8. Must be a multiple of 8 and ≥ 32.
- `FAS_PATTERN`, 16'hF628 — frame alignment word, MSB transmitted first.
- `LOS_COUNT`, 3 — consecutive FAS mismatches in SYNC that force a return to HUNT.

Ports:
- `i_clk`  in  1  — system clock.
- `i_rst_n`  in  1  — asynchronous, active-low reset.
- `i_otn_rx_data`  in  1  — serial line bit.
- `i_otn_rx_valid`  in  1  — bit strobe; a bit is accepted only in cycles where this is high.
- `i_arq_en`  in  1  — board switch; enables ack/nack generation.
- `o_frame_data`  out  1  — payload bit to the demapper.
- `o_frame_data_valid`  out  1  — qualifies `o_frame_data`.
- `o_frame_data_fas`  out  1  — high together with the first payload bit of each frame.
- `o_frame_end`  out  1  — high together with the last payload bit of each frame.
- `o_in_sync`  out  1  — high while the state is SYNC.
- `o_otn_tx_ack`  out  1  — one-cycle pulse: frame received with good BIP.
- `o_retrans_req`  out  1  — one-cycle pulse: frame received with bad BIP.

## Operation
- Bit index counter `idx` runs 0..FRAME_BITS-1, is $clog2(FRAME_BITS) wide, advances once per accepted bit, and wraps from FRAME_BITS-1 to 0.
- Bit layout within a frame:
  - FAS = idx 0–15.
  - Payload = idx 16..FRAME_BITS-9.
  - BIP trailer = idx FRAME_BITS-8..FRAME_BITS-1.
- A 16-bit shift register holds the last 16 accepted bits, with the newest bit at the LSB.
- The FAS compare runs on the window after shifting in the current bit.
- States:
  - **HUNT:** compare on every accepted bit. On a match, go to PRESYNC and set `idx` to 16.
  - **PRESYNC:** compare only at the accepted bit with idx = 15. Match → SYNC. Mismatch → HUNT.
  - **SYNC:** compare at idx = 15.
    - A match clears the mismatch counter.
    - A mismatch increments it; on reaching LOS_COUNT, go to HUNT and clear the counter.
    - The frame's payload is still forwarded after a mismatch below LOS_COUNT (flywheel).
- Payload is forwarded only for frames where the state is SYNC at idx = 16. The first forwarded frame is the one following the second good FAS.
- BIP-8 computation:
  - Payload bit p (p = idx−16) is XORed into `bip[p mod 8]`.
  - `bip` clears at idx = 16.
  - Trailer bit j (idx = FRAME_BITS-8+j) is compared against `bip[j]`, and any difference sets a sticky error flag.
- Verdict at the accepted bit with idx = FRAME_BITS-1, for forwarded frames only:
  - Good BIP → `o_otn_tx_ack`.
  - Bad BIP → `o_retrans_req`.
  - Both outputs are gated by `i_arq_en` and by `ARQ_EN`.
- A transition to HUNT at idx = 15 suppresses payload forwarding and the verdict for that frame.

## Timing
- All outputs are registered and low at reset. `o_in_sync` is also 0 at reset.
- Reset:
  - Assertion of `i_rst_n` clears the state to HUNT and clears `idx`, the shift register, `bip`, the mismatch counter and the error flag, all immediately (asynchronously).
  - Deassertion is synchronized externally.
- Latency: payload bit out one clock after it was accepted. `o_frame_data_fas` and `o_frame_end` are aligned with the corresponding `o_frame_data_valid`.
- Ack/nack pulse is asserted one clock after the accepted bit with idx = FRAME_BITS-1, and lasts exactly one cycle.
- Behaviour when `i_rst_n` is high and `i_otn_rx_valid` is low:
  - `idx` and the shift register hold; the state machine makes no transition.
  - `o_frame_data_valid` is low in the following cycle.
  - Gaps of any length are tolerated.
- `o_in_sync` rises one clock after the PRESYNC→SYNC compare and falls one clock after the LOS_COUNT-th mismatch.
- `i_arq_en` is sampled at the verdict cycle only.

## Configuration
- `OTN_RX_ARQ_EN` defined:
  - BIP-8 accumulator, error flag and ack/nack logic are compiled in.
  - Outputs pulse per the rules above when `i_arq_en` = 1.
- `OTN_RX_ARQ_EN` undefined:
  - BIP logic is removed.
  - `o_otn_tx_ack` and `o_retrans_req` are tied to 0.
  - `i_arq_en` is ignored.
  - Framing and payload forwarding are unchanged; trailer bits are still not forwarded.

## Test plan
- **Reset:** drive `i_rst_n` = 0 mid-stream → all outputs 0 in the same cycle; state HUNT; after release, no valid output until two good FAS have been received.
- **Alignment:** FRAME_BITS = 64, 5 random bits, then frames with FAS F628, a 40-bit payload and correct BIP → `o_in_sync` high after the 2nd FAS; 40 valid bits per frame from frame 2 onward; `o_frame_data_fas`/`o_frame_end` on the first and last bits; `o_otn_tx_ack` pulse per frame.
- **BIP error:** in sync with `i_arq_en` = 1, flip payload bit p = 3 → `o_retrans_req` one cycle after the last trailer bit, no ack. Same stimulus with `i_arq_en` = 0 → neither pulse.
- **Flywheel/loss:**
  - Corrupt 2 consecutive FAS → `o_in_sync` stays 1 and payload is still forwarded.
  - Corrupt 3 consecutive FAS → `o_in_sync` falls one clock after the 3rd, and that frame produces no payload and no verdict.
  - Resync after 2 good FAS.
- **Strobe gaps:** `i_otn_rx_valid` toggling with random duty (including 10-cycle gaps) in sync → payload bits and the verdict are identical to the gapless run.
- **Macro off:** compile without `OTN_RX_ARQ_EN` and inject a bad BIP → `o_otn_tx_ack` = `o_retrans_req` = 0 always; payload output identical.
